pll_lock_sequencer: RTL
=======================

PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  STABLE_CYCLES, 1024, consecutive synchronized-lock cycles required before reset release (legal range >=1)
  HOLD_CYCLES, 16, minimum reset-hold cycles after lock loss or resync (legal range >=1)
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clock_in  input  1  sole clock (PLL output domain); all logic rising-edge
  reset_n  input  1  asynchronous active-low reset
  locked  input  1  raw PLL lock flag, asynchronous to clock_in
  resync  input  1  synchronous request to re-run the sequence, sampled each edge
  sys_reset_n  output  1  registered active-low synchronous reset for downstream logic
  ready  output  1  registered; 1 only in RUN
  lost_lock  output  1  registered one-cycle pulse on lock loss from RUN
  loss_count  output  8  saturating count of lock losses from RUN
  state  output  2  current FSM state encoding

Function
REQ-003 locked SHALL pass through a 2-flop synchronizer (locked_s); no other logic SHALL sample raw locked.
REQ-004 The FSM SHALL have four states: WAIT_LOCK=0, STABILIZE=1, RUN=2, HOLD=3.
REQ-005 A single counter SHALL be sized to hold max(STABLE_CYCLES, HOLD_CYCLES)-1 and SHALL be cleared on every state entry.
REQ-006 WAIT_LOCK: when locked_s=1, go to STABILIZE; otherwise stay.
REQ-007 STABILIZE: if locked_s=0, go to WAIT_LOCK with no loss count; else if counter==STABLE_CYCLES-1, go to RUN; else increment the counter.
REQ-008 RUN: if locked_s=0, go to HOLD, pulse lost_lock, and increment loss_count; else if resync=1, go to HOLD with no pulse and no count.
REQ-009 Simultaneous locked_s=0 and resync=1 in RUN SHALL be treated as a lock loss: pulse lost_lock and increment loss_count.
REQ-010 HOLD: locked_s SHALL be ignored; if counter==HOLD_CYCLES-1, go to WAIT_LOCK; else increment the counter.
REQ-011 resync SHALL be ignored in every state except RUN.
REQ-012 sys_reset_n and ready SHALL each equal 1 exactly when the registered state is RUN, updated on the same edge as the state.
REQ-013 Timing: if raw locked is first sampled high at edge 0 and stays high, state SHALL be STABILIZE after edge 2 and RUN (sys_reset_n=1) after edge STABLE_CYCLES+2.
REQ-014 Timing: if raw locked is first sampled low at edge L while in RUN, HOLD, sys_reset_n=0 and lost_lock=1 SHALL hold after edge L+2; lost_lock SHALL be 0 after edge L+3; WAIT_LOCK SHALL follow after edge L+2+HOLD_CYCLES.
REQ-015 loss_count SHALL saturate at 255 and never wrap; the lost_lock pulse SHALL still occur while saturated.
REQ-016 lost_lock SHALL be 1 for exactly one cycle per loss event and 0 at all other times.

Reset
REQ-017 reset_n=0 SHALL asynchronously clear: both synchronizer flops, state (WAIT_LOCK), counter, sys_reset_n (0), ready, lost_lock, and loss_count.
REQ-018 Reset asserted in any state, including mid-count, SHALL abort the sequence; operation SHALL resume from WAIT_LOCK on the first edge after release, with loss_count=0.

Verification
REQ-019 The bench SHALL use STABLE_CYCLES=8 and HOLD_CYCLES=4 and cover:
  Clean lock: locked high from edge 0 -> state=1 after edge 2; sys_reset_n=1, ready=1, state=2 after edge 10.
  Glitch in STABILIZE: locked low for 3 cycles during count -> return to WAIT_LOCK; loss_count stays 0; full 8-cycle count restarts.
  Loss in RUN: locked sampled low at edge L -> lost_lock=1 only after L+2; loss_count=1; state=3 for 4 cycles; state=0 after L+6; re-lock after 8 further stable cycles.
  Resync: resync=1 for one cycle in RUN -> HOLD for 4 cycles with no lost_lock and unchanged loss_count; resync in WAIT_LOCK -> no effect.
  Simultaneous events and saturation: resync and lock loss in the same cycle -> counted as a loss; 260 loss cycles -> loss_count=255 with a pulse on every loss.
  Async reset mid-STABILIZE (counter=5) -> all outputs 0 immediately without a clock edge; after release, clean 10-edge lock sequence again.

Source files
------------

// File: rtl/pll_lock_sequencer.sv
// rtl/pll_lock_sequencer.sv - PLL lock qualification and downstream reset sequencer
//
// Holds downstream logic in reset until the PLL lock flag has been stable for
// STABLE_CYCLES clocks, then releases it. A lock loss (or a resync request)
// while running re-asserts reset for at least HOLD_CYCLES before the lock
// qualification starts over.
//
// Ports:
//   clock_in     sole clock, PLL output domain
//   reset_n      asynchronous active-low reset
//   locked       raw PLL lock flag, asynchronous to clock_in
//   resync       synchronous request to re-run the sequence (honoured in RUN only)
//   sys_reset_n  registered active-low reset for downstream logic (1 only in RUN)
//   ready        registered, 1 only in RUN
//   lost_lock    one-cycle pulse on every lock loss from RUN
//   loss_count   saturating count of lock losses from RUN
//   state        current state: 0 WAIT_LOCK, 1 STABILIZE, 2 RUN, 3 HOLD
module pll_lock_sequencer #(
    parameter int STABLE_CYCLES = 1024,
    parameter int HOLD_CYCLES   = 16
) (
    input  logic       clock_in,
    input  logic       reset_n,
    input  logic       locked,
    input  logic       resync,
    output logic       sys_reset_n,
    output logic       ready,
    output logic       lost_lock,
    output logic [7:0] loss_count,
    output logic [1:0] state
);

    localparam int CNT_MAX = ((STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES) - 1;
    localparam int CW      = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABILIZE = 2'd1,
        RUN       = 2'd2,
        HOLD      = 2'd3
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          loss_event;

    // Two-flop synchronizer; locked_s is the only view of the PLL flag.
    logic locked_m;
    logic locked_s;

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            locked_m <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            locked_m <= locked;
            locked_s <= locked_m;
        end
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The counter is zeroed on every transition so each state that counts
    // starts from 0 on entry; it only increments while staying put.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        loss_event = 1'b0;
        case (state_q)
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = STABILIZE;
                    cnt_d   = '0;
                end
            end
            STABILIZE: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RUN: begin
                // Lock loss takes priority over a coincident resync.
                if (!locked_s) begin
                    state_d    = HOLD;
                    cnt_d      = '0;
                    loss_event = 1'b1;
                end else if (resync) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end
            end
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they change on the same
    // edge as the state register.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            sys_reset_n <= 1'b0;
            ready       <= 1'b0;
            lost_lock   <= 1'b0;
            loss_count  <= 8'd0;
        end else begin
            sys_reset_n <= (state_d == RUN);
            ready       <= (state_d == RUN);
            lost_lock   <= loss_event;
            if (loss_event && (loss_count != 8'hFF)) begin
                loss_count <= loss_count + 8'd1;
            end
        end
    end

    assign state = state_q;

endmodule
